seq_divider: RTL
================

// Module: seq_divider
// PURPOSE
//   Iterative restoring divider: the inverse of the N-bit combinational multiplier.
//   Takes a 2N-bit product-width dividend and an N-bit divisor.
//   Returns a 2N-bit quotient and an N-bit remainder, one quotient bit per clock.
//   Sits beside the multiplier in the arithmetic datapath; a start/busy/done handshake sequences it.
// PARAMETERS
//   N  5  operand width; dividend/quotient are 2N bits, divisor/remainder N bits
// PORTS
//   clk        in   1     rising-edge clock; the only clock
//   rst        in   1     asynchronous, active-high reset
//   start      in   1     request; sampled on rising clk; accepted only when busy=0
//   dividend   in   2N    sampled on the accepting edge only
//   divisor    in   N     sampled on the accepting edge only
//   busy       out  1     high while a division is in progress
//   done       out  1     one-cycle pulse: results valid
//   quotient   out  2N    floor(dividend/divisor); held until next accepted start
//   remainder  out  N     dividend mod divisor; held until next accepted start
//   div_zero   out  1     divisor was 0 for the latest result; held with results
// BEHAVIOUR
//   - Reset (async, any time incl. mid-division): state=IDLE.
//     busy=0, done=0, div_zero=0, quotient=0, remainder=0.
//     Operation in flight is discarded; no done is produced for it.
//   - FSM states: IDLE, RUN, DONE.
//       IDLE/DONE + start=1 -> RUN: latch operands, clear iteration counter, busy=1.
//       IDLE + start=0 -> IDLE. DONE + start=0 -> IDLE.
//       RUN -> RUN while counter < 2N-1, counter++ each cycle.
//       RUN with counter = 2N-1 -> DONE: commit quotient/remainder/div_zero, busy=0, done=1.
//   - done is high exactly one cycle (the DONE state).
//     Back-to-back start in DONE is accepted; done still pulses that cycle.
//   - start while busy=1 is ignored. Operands and state are unaffected.
//   - Latency: accepting edge E0 -> done=1 and results valid after edge E0+2N.
//     busy is high from after E0 until edge E0+2N.
//   - Iteration (restoring, MSB first), one per RUN cycle:
//       P (N+1 bits) = {R,next dividend bit}
//       if P >= {0,divisor}: R = P-divisor, q bit = 1; else R = P[N-1:0], q bit = 0.
//     Partial remainder R starts at 0 and always satisfies R < divisor, so N bits suffice.
//     Only the (N+1)-bit P needs the extra bit.
//   - Divisor = 0: takes the full latency.
//     Results: quotient = all ones (2^(2N)-1), remainder = 0, div_zero = 1.
//   - div_zero = 0 for every nonzero divisor.
//   - quotient/remainder change only on the DONE transition or reset.
//     They do not change on the accepting edge. Intermediate values never appear on the outputs.
//   - Invariant for divisor != 0: quotient*divisor + remainder == dividend, remainder < divisor.
// TESTING (N=5 unless noted; check at done)
//   1. dividend=1023, divisor=31 -> quotient=33, remainder=0, div_zero=0, done 10 cycles after start edge.
//   2. dividend=100, divisor=7 -> quotient=14, remainder=2; dividend=0, divisor=5 -> 0, 0.
//   3. dividend=77, divisor=0 -> quotient=1023, remainder=0, div_zero=1; next 10/3 run clears div_zero.
//   4. start with 50/5, pulse start with 9/9 at cycle 4 -> ignored; result 10 r 0, exactly one done.
//   5. rst high at cycle 5 of a run -> all outputs 0 immediately; no done; new 21/4 after reset -> 5 r 1.
//   6. Exhaustive: all dividend in [0,1023] x divisor in [1,31], starts issued in DONE cycle back-to-back.
//      Every result must satisfy the invariant; errors are counted and the count is printed at end.

Source files
------------

// File: rtl/seq_divider.sv
// Iterative restoring divider: 2N-bit dividend by N-bit divisor, one quotient bit per clock.
// Start/busy/done handshake; results and div_zero hold until the next completed division.
module seq_divider #(
    parameter int N = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           div_zero
);

    localparam int CW = $clog2(2 * N);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [CW-1:0] LAST = CW'(2 * N - 1);

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] work_q, work_d;
    logic [N-1:0]   dvs_q, dvs_d;
    logic [N-1:0]   rem_q, rem_d;
    logic [2*N-1:0] quotient_q, quotient_d;
    logic [N-1:0]   remainder_q, remainder_d;
    logic           dz_q, dz_d;

    logic [N:0]     p;
    logic           ge;
    logic [N-1:0]   rem_nx;
    logic [2*N-1:0] work_nx;

    // work_q shifts dividend bits out of the MSB while quotient bits enter at the LSB,
    // so after 2N iterations it holds the full quotient.
    always_comb begin
        p       = {rem_q, work_q[2*N-1]};
        ge      = (p >= {1'b0, dvs_q});
        rem_nx  = ge ? (p[N-1:0] - dvs_q) : p[N-1:0];
        work_nx = {work_q[2*N-2:0], ge};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dz_d        = dz_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    work_d  = dividend;
                    dvs_d   = divisor;
                    rem_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                work_d = work_nx;
                rem_d  = rem_nx;
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    // A zero divisor yields all-ones naturally; the remainder is forced to 0.
                    if (dvs_q == '0) begin
                        quotient_d  = '1;
                        remainder_d = '0;
                        dz_d        = 1'b1;
                    end else begin
                        quotient_d  = work_nx;
                        remainder_d = rem_nx;
                        dz_d        = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dz_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dz_q        <= dz_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = dz_q;

endmodule
